// File: rtl/id_ex_pipe_if.sv
// ID/EX pipeline bundle.
// The master side is the decode stage and pipeline control. It drives the ID_* fields plus hold and flush.
// The slave side is the ID/EX register. It drives the EX_* fields and the load-use stall.
interface id_ex_pipe_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
);
    logic              ID_valid;
    logic [XLEN-1:0]   ID_pc;
    logic [XLEN-1:0]   ID_rs1_data;
    logic [XLEN-1:0]   ID_rs2_data;
    logic [XLEN-1:0]   ID_imm;
    logic [4:0]        ID_rs1;
    logic [4:0]        ID_rs2;
    logic [4:0]        ID_rd;
    logic              ID_use_rs1;
    logic              ID_use_rs2;
    logic              ID_regwrite;
    logic              ID_memread;
    logic              ID_memwrite;
    logic [CTRL_W-1:0] ID_ctrl;
    logic              hold;
    logic              flush;

    logic              stall;
    logic              EX_valid;
    logic [XLEN-1:0]   EX_pc;
    logic [XLEN-1:0]   EX_rs1_data;
    logic [XLEN-1:0]   EX_rs2_data;
    logic [XLEN-1:0]   EX_imm;
    logic [4:0]        EX_rs1;
    logic [4:0]        EX_rs2;
    logic [4:0]        EX_rd;
    logic              EX_regwrite;
    logic              EX_memread;
    logic              EX_memwrite;
    logic [CTRL_W-1:0] EX_ctrl;

    modport master (
        output ID_valid, ID_pc, ID_rs1_data, ID_rs2_data, ID_imm,
               ID_rs1, ID_rs2, ID_rd, ID_use_rs1, ID_use_rs2,
               ID_regwrite, ID_memread, ID_memwrite, ID_ctrl, hold, flush,
        input  stall, EX_valid, EX_pc, EX_rs1_data, EX_rs2_data, EX_imm,
               EX_rs1, EX_rs2, EX_rd, EX_regwrite, EX_memread, EX_memwrite,
               EX_ctrl
    );

    modport slave (
        input  ID_valid, ID_pc, ID_rs1_data, ID_rs2_data, ID_imm,
               ID_rs1, ID_rs2, ID_rd, ID_use_rs1, ID_use_rs2,
               ID_regwrite, ID_memread, ID_memwrite, ID_ctrl, hold, flush,
        output stall, EX_valid, EX_pc, EX_rs1_data, EX_rs2_data, EX_imm,
               EX_rs1, EX_rs2, EX_rd, EX_regwrite, EX_memread, EX_memwrite,
               EX_ctrl
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and branch flush.
// Optional macro IDEX_HAZARD_STAT_EN adds two saturating counters, stall_cnt and flush_cnt.
// When the macro is undefined, those ports and their counters do not exist.
// A bubble is all-zero, so the forwarding unit can never match a bubble's rd.
module id_ex_pipe #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    id_ex_pipe_if.slave bus
`ifdef IDEX_HAZARD_STAT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic [CTRL_W-1:0] ctrl;
    } ex_stage_t;

    ex_stage_t ex_q, ex_d;
    logic      load_use;
    logic      rs1_hit, rs2_hit;

    // Detect a load in EX whose non-x0 rd is a source of the ID instruction.
    always_comb begin
        rs1_hit  = bus.ID_use_rs1 && (bus.ID_rs1 == ex_q.rd);
        rs2_hit  = bus.ID_use_rs2 && (bus.ID_rs2 == ex_q.rd);
        load_use = ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0)
                   && bus.ID_valid && (rs1_hit || rs2_hit);
    end

    // A flush kills the dependent instruction anyway, so it must not stall upstream.
    assign bus.stall = load_use && !bus.flush;

    // Next-state priority: hold, then flush, then load-use bubble, then capture.
    always_comb begin
        ex_d = ex_q;
        if (bus.hold) begin
            ex_d = ex_q;
        end else if (bus.flush || load_use) begin
            ex_d = '0;
        end else begin
            ex_d.valid    = bus.ID_valid;
            ex_d.pc       = bus.ID_pc;
            ex_d.rs1_data = bus.ID_rs1_data;
            ex_d.rs2_data = bus.ID_rs2_data;
            ex_d.imm      = bus.ID_imm;
            ex_d.rs1      = bus.ID_rs1;
            ex_d.rs2      = bus.ID_rs2;
            ex_d.rd       = bus.ID_rd;
            // Control is forced off for an invalid slot, so it can never write state.
            ex_d.regwrite = bus.ID_valid && bus.ID_regwrite;
            ex_d.memread  = bus.ID_valid && bus.ID_memread;
            ex_d.memwrite = bus.ID_valid && bus.ID_memwrite;
            ex_d.ctrl     = bus.ID_valid ? bus.ID_ctrl : '0;
        end
    end

    // Pipeline register. Reset clears EX_valid asynchronously, so stall drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.EX_valid    = ex_q.valid;
    assign bus.EX_pc       = ex_q.pc;
    assign bus.EX_rs1_data = ex_q.rs1_data;
    assign bus.EX_rs2_data = ex_q.rs2_data;
    assign bus.EX_imm      = ex_q.imm;
    assign bus.EX_rs1      = ex_q.rs1;
    assign bus.EX_rs2      = ex_q.rs2;
    assign bus.EX_rd       = ex_q.rd;
    assign bus.EX_regwrite = ex_q.regwrite;
    assign bus.EX_memread  = ex_q.memread;
    assign bus.EX_memwrite = ex_q.memwrite;
    assign bus.EX_ctrl     = ex_q.ctrl;

`ifdef IDEX_HAZARD_STAT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Hazard statistics: count unfrozen stall and flush edges, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.stall && !bus.hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (bus.flush && !bus.hold && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed testbench for id_ex_pipe.
// Counter checks run only when IDEX_HAZARD_STAT_EN is defined.
module tb_id_ex_pipe;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    id_ex_pipe_if #(.XLEN(32), .CTRL_W(8)) bus ();

`ifdef IDEX_HAZARD_STAT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    id_ex_pipe #(.XLEN(32), .CTRL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef IDEX_HAZARD_STAT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic valid, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic use1,
                          input logic [4:0] rs2, input logic use2,
                          input logic [4:0] rd, input logic regwrite,
                          input logic memread, input logic [7:0] ctrl);
        bus.ID_valid    = valid;
        bus.ID_pc       = pc;
        bus.ID_rs1_data = pc + 32'h1;
        bus.ID_rs2_data = pc + 32'h2;
        bus.ID_imm      = pc + 32'h3;
        bus.ID_rs1      = rs1;
        bus.ID_use_rs1  = use1;
        bus.ID_rs2      = rs2;
        bus.ID_use_rs2  = use2;
        bus.ID_rd       = rd;
        bus.ID_regwrite = regwrite;
        bus.ID_memread  = memread;
        bus.ID_memwrite = 1'b0;
        bus.ID_ctrl     = ctrl;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        set_id(0, 32'h0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 8'h00);
        #12;
        chk("rst_valid", 32'(bus.EX_valid), 32'd0);
        chk("rst_pc",    bus.EX_pc,         32'h0);
        chk("rst_stall", 32'(bus.stall),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic capture with one cycle of latency.
        set_id(1, 32'h100, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 8'hA5);
        tick();
        chk("cap_pc",       bus.EX_pc,            32'h100);
        chk("cap_rd",       32'(bus.EX_rd),       32'd5);
        chk("cap_regwrite", 32'(bus.EX_regwrite), 32'd1);
        chk("cap_valid",    32'(bus.EX_valid),    32'd1);
        chk("cap_ctrl",     32'(bus.EX_ctrl),     32'hA5);
        chk("cap_rs1data",  bus.EX_rs1_data,      32'h101);
        chk("cap_imm",      bus.EX_imm,           32'h103);

        // Reset asserted mid-cycle clears outputs immediately.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.EX_valid), 32'd0);
        chk("arst_pc",    bus.EX_pc,         32'h0);
        chk("arst_rd",    32'(bus.EX_rd),    32'd0);
        #1;
        rst_n = 1'b1;

        // Load-use on rs1: one stall cycle, one bubble, then capture.
        set_id(1, 32'h104, 5'd1, 1, 5'd2, 0, 5'd7, 1, 1, 8'h11);
        tick();
        chk("ld_memread", 32'(bus.EX_memread), 32'd1);
        set_id(1, 32'h108, 5'd7, 1, 5'd3, 0, 5'd8, 1, 0, 8'h22);
        #1;
        chk("lu_stall", 32'(bus.stall), 32'd1);
        tick();
        chk("lu_bub_valid", 32'(bus.EX_valid), 32'd0);
        chk("lu_bub_rd",    32'(bus.EX_rd),    32'd0);
        chk("lu_bub_pc",    bus.EX_pc,         32'h0);
        chk("lu_stall_off", 32'(bus.stall),    32'd0);
        tick();
        chk("lu_re_pc",    bus.EX_pc,         32'h108);
        chk("lu_re_rd",    32'(bus.EX_rd),    32'd8);
        chk("lu_re_valid", 32'(bus.EX_valid), 32'd1);

        // The index matches but use_rs1=0, so there is no hazard.
        set_id(1, 32'h10C, 5'd1, 1, 5'd2, 0, 5'd7, 1, 1, 8'h00);
        tick();
        set_id(1, 32'h110, 5'd7, 0, 5'd3, 1, 5'd9, 1, 0, 8'h00);
        #1;
        chk("nouse_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("nouse_pc", bus.EX_pc, 32'h110);

        // A load to x0 never stalls.
        set_id(1, 32'h114, 5'd1, 1, 5'd2, 0, 5'd0, 1, 1, 8'h00);
        tick();
        set_id(1, 32'h118, 5'd4, 1, 5'd0, 1, 5'd9, 1, 0, 8'h00);
        #1;
        chk("x0_stall", 32'(bus.stall), 32'd0);

        // A non-load producer never stalls.
        set_id(1, 32'h11C, 5'd1, 1, 5'd2, 0, 5'd7, 1, 0, 8'h00);
        tick();
        set_id(1, 32'h120, 5'd7, 1, 5'd0, 0, 5'd9, 1, 0, 8'h00);
        #1;
        chk("alu_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("alu_cap_pc", bus.EX_pc, 32'h120);

        // Flush overrides load-use: no stall, and a bubble is loaded.
        set_id(1, 32'h124, 5'd1, 1, 5'd2, 0, 5'd7, 1, 1, 8'h00);
        tick();
        set_id(1, 32'h128, 5'd7, 1, 5'd0, 0, 5'd9, 1, 0, 8'h00);
        bus.flush = 1'b1;
        #1;
        chk("fl_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.flush = 1'b0;
        chk("fl_valid", 32'(bus.EX_valid), 32'd0);
        chk("fl_pc",    bus.EX_pc,         32'h0);
`ifdef IDEX_HAZARD_STAT_EN
        chk("fl_flush_cnt", flush_cnt, 32'd1);
        chk("fl_stall_cnt", stall_cnt, 32'd1);
`endif

        // Hold outranks flush: EX freezes for three edges.
        set_id(1, 32'h200, 5'd1, 1, 5'd2, 0, 5'd3, 1, 0, 8'h00);
        tick();
        set_id(1, 32'h300, 5'd1, 1, 5'd2, 0, 5'd4, 1, 0, 8'h00);
        bus.hold  = 1'b1;
        bus.flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_pc",    bus.EX_pc,         32'h200);
            chk("hold_valid", 32'(bus.EX_valid), 32'd1);
        end
        bus.hold = 1'b0;
        tick();
        bus.flush = 1'b0;
        chk("hold_rel_valid", 32'(bus.EX_valid), 32'd0);
        chk("hold_rel_pc",    bus.EX_pc,         32'h0);
`ifdef IDEX_HAZARD_STAT_EN
        chk("hold_flush_cnt", flush_cnt, 32'd2);
`endif

        // An invalid slot is captured as is, with its control bits forced to zero.
        set_id(0, 32'h400, 5'd1, 1, 5'd2, 0, 5'd6, 1, 1, 8'h5A);
        tick();
        chk("inv_pc",       bus.EX_pc,            32'h400);
        chk("inv_regwrite", 32'(bus.EX_regwrite), 32'd0);
        chk("inv_memread",  32'(bus.EX_memread),  32'd0);
        chk("inv_ctrl",     32'(bus.EX_ctrl),     32'd0);

        // Back-to-back dependent loads: each one takes exactly one bubble.
        set_id(1, 32'h500, 5'd1, 1, 5'd2, 0, 5'd9, 1, 1, 8'h00);
        tick();
        set_id(1, 32'h504, 5'd9, 1, 5'd0, 0, 5'd10, 1, 1, 8'h00);
        #1;
        chk("chain1_stall", 32'(bus.stall), 32'd1);
        tick();
        chk("chain1_bub", 32'(bus.EX_valid), 32'd0);
        tick();
        chk("chain1_rd", 32'(bus.EX_rd), 32'd10);
        set_id(1, 32'h508, 5'd0, 0, 5'd10, 1, 5'd11, 1, 0, 8'h00);
        #1;
        chk("chain2_stall", 32'(bus.stall), 32'd1);
        tick();
        chk("chain2_bub", 32'(bus.EX_valid), 32'd0);
        tick();
        chk("chain2_pc", bus.EX_pc, 32'h508);

        // Reset during a stall drops the stall immediately.
        set_id(1, 32'h600, 5'd1, 1, 5'd2, 0, 5'd7, 1, 1, 8'h00);
        tick();
        set_id(1, 32'h604, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 8'h00);
        #1;
        chk("rs_stall_on", 32'(bus.stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rs_stall_off", 32'(bus.stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef IDEX_HAZARD_STAT_EN
        // The stall counter saturates instead of wrapping.
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 32'h700, 5'd1, 1, 5'd2, 0, 5'd7, 1, 1, 8'h00);
            tick();
            set_id(1, 32'h704, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 8'h00);
            tick();
        end
        chk("sat_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register with built-in load-use hazard detection, bubble insertion and branch flush.
- Sits between the decode stage and the EX stage.
- Supplies EX_rs1/EX_rs2/EX_rd and the control bits consumed by the EX-stage forwarding unit and ALU.
- Asserts a stall back to PC and IF/ID when a load is followed by a dependent instruction.

Parameters:
- XLEN, 32, data/PC width
- CTRL_W, 8, width of opaque ALU/branch control bundle passed through unchanged

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ID_valid  input  1  ID slot holds a real instruction
- ID_pc  input  XLEN  PC of ID instruction
- ID_rs1_data  input  XLEN  register file read data A
- ID_rs2_data  input  XLEN  register file read data B
- ID_imm  input  XLEN  decoded immediate
- ID_rs1  input  5  source register 1 index
- ID_rs2  input  5  source register 2 index
- ID_rd  input  5  destination index
- ID_use_rs1  input  1  instruction reads rs1
- ID_use_rs2  input  1  instruction reads rs2
- ID_regwrite  input  1  writes rd
- ID_memread  input  1  load
- ID_memwrite  input  1  store
- ID_ctrl  input  CTRL_W  pass-through control
- hold  input  1  global downstream stall (dmem busy); freeze register
- flush  input  1  branch/jump resolved taken in EX; kill ID instruction
- stall  output  1  load-use stall request to PC and IF/ID
- EX_valid  output  1  registered ID_valid
- EX_pc, EX_rs1_data, EX_rs2_data, EX_imm  output  XLEN each  registered copies
- EX_rs1, EX_rs2, EX_rd  output  5 each  registered indices
- EX_regwrite, EX_memread, EX_memwrite  output  1 each  registered control
- EX_ctrl  output  CTRL_W  registered control bundle

Behaviour:
- Reset: asynchronous on rst_n low. Every EX_* output goes to 0. Register holds a bubble.
- Latency: one cycle, ID inputs to EX outputs.
- load_use (combinational) = EX_valid & EX_memread & EX_rd!=0 & ID_valid & ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd)).
- stall = load_use & ~flush. Combinational, no register.
- Update priority per rising edge, highest first:
  1. hold=1: all EX_* keep their values. Overrides flush and load_use, and upstream is frozen by the same hold.
  2. flush=1: load a bubble.
  3. load_use=1: load a bubble. Upstream holds the ID instruction, so it is re-presented next cycle and is then no longer dependent.
  4. Otherwise: capture all ID_* inputs.
- Bubble: every EX_* output set to 0, so EX_valid=0, EX_regwrite=0, EX_memread=0, EX_memwrite=0, EX_rd=0. Fields are zeroed, not held, so the forwarding unit never matches a bubble.
- ID_valid=0 with normal load: captured as is. Control bits are additionally gated to 0 whenever ID_valid=0.
- Back-to-back loads with a chain of dependencies: each dependent instruction takes exactly one bubble.
- Load with rd=x0: never stalls.
- rst_n asserted mid-stall: stall drops immediately, because EX_valid is cleared asynchronously.

Optional Feature:
- Macro: IDEX_HAZARD_STAT_EN.
- When defined, add outputs stall_cnt (32) and flush_cnt (32). Both reset to 0 asynchronously.
  - stall_cnt increments on each edge where stall=1 & hold=0.
  - flush_cnt increments on each edge where flush=1 & hold=0.
  - Both saturate at 32'hFFFFFFFF.
- When undefined, these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Reset/capture: reset, then present ID_pc=0x100, rd=5, regwrite=1, valid=1 → after one edge EX_pc=0x100, EX_rd=5, EX_regwrite=1, EX_valid=1. Assert rst_n=0 mid-cycle → all EX_* read 0 immediately.
- Load-use:
  - EX holds a load with rd=7. ID has rs1=7, use_rs1=1 → stall=1 that cycle.
  - Next edge EX is a bubble (EX_valid=0, EX_rd=0). Re-presented instruction then captures and stall=0.
  - Same case with use_rs1=0 → stall=0.
- x0 and non-load: EX holds a load with rd=0 and ID rs2=0 → stall=0. EX holds an ALU op with rd=7 and ID rs1=7 → stall=0, captured normally.
- Flush vs load-use: load_use and flush both 1 → stall=0 and a bubble is loaded. With IDEX_HAZARD_STAT_EN defined, flush_cnt increments by 1 and stall_cnt is unchanged.
- Hold priority: EX holds pc=0x200. Assert hold with flush=1 and new ID_pc=0x300 for 3 cycles → EX_pc stays 0x200 and EX_valid stays 1. Release hold → bubble loaded on the next edge.
- Counter saturation (IDEX_HAZARD_STAT_EN defined): force stall_cnt to 32'hFFFFFFFE, then cause 3 stall cycles → final value 32'hFFFFFFFF.
